// File: rtl/facto_accel_pkg.sv
// Shared definitions for the factorial accelerator: register word indices,
// STATUS bit positions and FSM state encoding.
package facto_accel_pkg;

  localparam logic [2:0] A_OPSTART = 3'd0;
  localparam logic [2:0] A_OPCLEAR = 3'd1;
  localparam logic [2:0] A_INTREN  = 3'd2;
  localparam logic [2:0] A_N       = 3'd3;
  localparam logic [2:0] A_K       = 3'd4;
  localparam logic [2:0] A_STATUS  = 3'd5;
  localparam logic [2:0] A_RES_H   = 3'd6;
  localparam logic [2:0] A_RES_L   = 3'd7;

  localparam int B_DONE = 0;
  localparam int B_BUSY = 1;
  localparam int B_OVF  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MUL,
    S_NEXT,
    S_DONE
  } state_e;

endpackage

// File: rtl/facto_accel_seq_mult.sv
// Unsigned RW x DW shift-add multiplier, one multiplier bit per cycle.
// done flags the final step: product is complete after that edge.
module facto_seq_mult #(
  parameter int DW = 64,
  parameter int RW = 2*DW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [RW-1:0]    a,
  input  logic [DW-1:0]    b,
  output logic             busy,
  output logic             done,
  output logic [RW+DW-1:0] product
);

  localparam int PW = RW + DW;
  localparam int CW = $clog2(DW + 1);

  logic [PW-1:0] mcand;
  logic [DW-1:0] mplier;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      product <= '0;
    end else if (abort) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      mcand   <= {{DW{1'b0}}, a};
      mplier  <= b;
      product <= '0;
      cnt     <= CW'(DW);
      busy    <= 1'b1;
    end else if (busy) begin
      if (mplier[0]) product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

  assign done = busy && (cnt == CW'(1));

endmodule

// File: rtl/facto_accel.sv
// Factorial / falling-factorial accelerator on a simple slave bus with
// sticky overflow, busy status and a level interrupt.
module facto_accel
  import facto_accel_pkg::*;
#(
  parameter int DW = 64,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          s_sel,
  input  logic          s_wr,
  input  logic [AW-1:0] s_addr,
  input  logic [DW-1:0] s_din,
  output logic [DW-1:0] s_dout,
  output logic          interrupt
);

  localparam int RW = 2*DW;
  localparam int PW = RW + DW;

  state_e        state, state_n;
  logic [DW-1:0] n, k, term, rem;
  logic [RW-1:0] acc, result;
  logic          intr_en, done_f, busy_f, ovf_f;

  logic          mult_start, mult_busy, mult_done, mult_last;
  logic [RW-1:0] mult_a;
  logic [DW-1:0] mult_b, load_rem;
  logic [PW-1:0] product;

  logic          in_map, wr, rd, op_start, op_clear;
  logic [2:0]    widx;

  assign in_map   = (s_addr[AW-1:6] == '0);
  assign widx     = s_addr[5:3];
  assign wr       = s_sel & s_wr & in_map;
  assign rd       = s_sel & ~s_wr & in_map;
  assign op_start = wr && (widx == A_OPSTART) && s_din[0] && !busy_f;
  assign op_clear = wr && (widx == A_OPCLEAR) && s_din[0];

  // K of zero, or larger than N, means the full factorial.
  assign load_rem  = ((k == '0) || (k > n)) ? n : k;
  assign mult_last = mult_busy & mult_done;

  always_comb begin
    state_n    = state;
    mult_start = 1'b0;
    mult_a     = product[RW-1:0];
    mult_b     = term - DW'(1);
    case (state)
      S_IDLE, S_DONE: if (op_start) state_n = S_LOAD;
      S_LOAD: begin
        if (n <= DW'(1)) state_n = S_DONE;
        else begin
          state_n    = S_MUL;
          mult_start = 1'b1;
          mult_a     = RW'(1);
          mult_b     = n;
        end
      end
      S_MUL: if (mult_last) state_n = S_NEXT;
      S_NEXT: begin
        if ((rem != DW'(1)) && (term > DW'(2))) begin
          state_n    = S_MUL;
          mult_start = 1'b1;
        end else state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
    if (op_clear) begin
      state_n    = S_IDLE;
      mult_start = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      n       <= '0;
      k       <= '0;
      intr_en <= 1'b0;
      acc     <= RW'(1);
      term    <= '0;
      rem     <= '0;
      result  <= RW'(1);
      done_f  <= 1'b0;
      busy_f  <= 1'b0;
      ovf_f   <= 1'b0;
    end else begin
      if (wr && widx == A_INTREN)          intr_en <= s_din[0];
      if (wr && widx == A_N && !busy_f)    n       <= s_din;
      if (wr && widx == A_K && !busy_f)    k       <= s_din;
      if (op_clear) begin
        state  <= S_IDLE;
        result <= RW'(1);
        done_f <= 1'b0;
        busy_f <= 1'b0;
        ovf_f  <= 1'b0;
      end else begin
        state <= state_n;
        case (state)
          S_LOAD: begin
            acc  <= RW'(1);
            term <= n;
            rem  <= load_rem;
          end
          S_NEXT: begin
            acc   <= product[RW-1:0];
            ovf_f <= ovf_f | (|product[PW-1:RW]);
            term  <= term - DW'(1);
            rem   <= rem - DW'(1);
          end
          S_DONE: begin
            result <= acc;
            done_f <= 1'b1;
            busy_f <= 1'b0;
          end
          default: ;
        endcase
        // Start is only accepted with busy low, i.e. from IDLE or a settled DONE.
        if (op_start) begin
          done_f <= 1'b0;
          ovf_f  <= 1'b0;
          busy_f <= 1'b1;
        end
      end
    end
  end

  facto_seq_mult #(.DW(DW), .RW(RW)) u_mult (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mult_start),
    .abort   (op_clear),
    .a       (mult_a),
    .b       (mult_b),
    .busy    (mult_busy),
    .done    (mult_done),
    .product (product)
  );

  always_comb begin
    s_dout = '0;
    if (rd) begin
      case (widx)
        A_INTREN: s_dout[0] = intr_en;
        A_N:      s_dout = n;
        A_K:      s_dout = k;
        A_STATUS: begin
          s_dout[B_DONE] = done_f;
          s_dout[B_BUSY] = busy_f;
          s_dout[B_OVF]  = ovf_f;
        end
        A_RES_H:  s_dout = result[RW-1:DW];
        A_RES_L:  s_dout = result[DW-1:0];
        default:  s_dout = '0;
      endcase
    end
  end

  assign interrupt = intr_en & done_f;

endmodule

// File: tb/tb_facto_accel.sv
// Randomised self-checking bench for facto_accel against a plain-arithmetic
// falling-factorial model.
module tb_facto_accel;

  localparam int DW = 64;
  localparam int AW = 16;
  localparam int RW = 2*DW;

  localparam logic [AW-1:0] R_OPSTART = 16'h00, R_OPCLEAR = 16'h08,
    R_INTREN = 16'h10, R_N = 16'h18, R_K = 16'h20, R_STATUS = 16'h28,
    R_RES_H = 16'h30, R_RES_L = 16'h38;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          s_sel, s_wr;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_din, s_dout;
  logic          interrupt;

  int n_chk = 0;
  int n_pass = 0;

  facto_accel #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_sel     (s_sel),
    .s_wr      (s_wr),
    .s_addr    (s_addr),
    .s_din     (s_din),
    .s_dout    (s_dout),
    .interrupt (interrupt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic bus_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    s_sel = 1'b1; s_wr = 1'b1; s_addr = a; s_din = d;
    @(posedge clk);
    #1;
    s_sel = 1'b0; s_wr = 1'b0; s_din = '0;
  endtask

  task automatic bus_rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
    s_sel = 1'b1; s_wr = 1'b0; s_addr = a;
    #1;
    d = s_dout;
    s_sel = 1'b0;
  endtask

  task automatic model(input int n, input int k, output logic [RW-1:0] res,
                       output logic ovf, output int m);
    logic [RW+DW-1:0] p;
    int rem;
    res = 1; ovf = 1'b0; m = 0;
    rem = (k == 0 || k > n) ? n : k;
    for (int t = n; rem > 0 && t > 1; t--) begin
      p   = {{DW{1'b0}}, res} * (RW+DW)'(t);
      ovf = ovf | (p[RW+DW-1:RW] != '0);
      res = p[RW-1:0];
      rem--;
      m++;
    end
  endtask

  task automatic wait_done(output int cyc);
    logic [DW-1:0] st;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      bus_rd(R_STATUS, st);
    end while (!st[0] && cyc < 5000);
  endtask

  task automatic get_result(output logic [RW-1:0] r);
    logic [DW-1:0] h, l;
    bus_rd(R_RES_H, h);
    bus_rd(R_RES_L, l);
    r = {h, l};
  endtask

  task automatic run(input string tag, input int n, input int k, output logic ovf_seen);
    logic [RW-1:0] exp_res, got_res;
    logic [DW-1:0] st;
    logic          exp_ovf;
    int            m, cyc;
    bus_wr(R_N, DW'(n));
    bus_wr(R_K, DW'(k));
    bus_wr(R_OPSTART, 1);
    wait_done(cyc);
    model(n, k, exp_res, exp_ovf, m);
    check({tag, ".lat"}, cyc, 2 + m*(DW+1));
    bus_rd(R_STATUS, st);
    check({tag, ".status"}, st, {exp_ovf, 2'b01});
    get_result(got_res);
    check({tag, ".res"}, got_res, exp_res);
    ovf_seen = st[2];
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [RW-1:0] r;
    logic          ov;
    int            cyc;
    reset_n = 1'b0; s_sel = 1'b0; s_wr = 1'b0; s_addr = '0; s_din = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    bus_rd(R_STATUS, d); check("rst.status", d, 0);
    get_result(r);       check("rst.res", r, 1);
    bus_rd(R_N, d);      check("rst.n", d, 0);
    check("rst.irq", interrupt, 0);
    s_addr = R_RES_L; #1;
    check("idle.dout", s_dout, 0);

    // Factorial with interrupt, then clear.
    bus_wr(R_INTREN, 1);
    run("n5", 5, 0, ov);
    check("n5.irq", interrupt, 1);
    bus_wr(R_OPCLEAR, 1);
    check("clr.irq", interrupt, 0);
    bus_rd(R_STATUS, d); check("clr.status", d, 0);
    get_result(r);       check("clr.res", r, 1);
    bus_rd(R_INTREN, d); check("clr.intren", d, 1);
    bus_rd(R_N, d);      check("clr.n", d, 5);
    bus_wr(R_INTREN, 0);

    run("n0", 0, 0, ov);
    run("n1", 1, 0, ov);
    run("n10k3", 10, 3, ov);
    run("n4k9", 4, 9, ov);
    run("n34", 34, 0, ov); check("n34.ovf", ov, 0);
    run("n35", 35, 0, ov); check("n35.ovf", ov, 1);

    // Addresses above the map are ignored and read as zero.
    bus_wr(16'h0058, 7);
    bus_rd(R_N, d);      check("oom.n", d, 35);
    bus_rd(16'h0078, d); check("oom.rd", d, 0);

    // Abort mid-multiply.
    bus_wr(R_N, 20);
    bus_wr(R_K, 0);
    bus_wr(R_OPSTART, 1);
    repeat (10) @(posedge clk);
    bus_wr(R_OPCLEAR, 1);
    bus_rd(R_STATUS, d); check("abort.status", d, 0);
    get_result(r);       check("abort.res", r, 1);
    run("n3", 3, 0, ov);

    // Operands locked and start ignored while busy.
    bus_wr(R_N, 6);
    bus_wr(R_K, 0);
    bus_wr(R_OPSTART, 1);
    repeat (3) @(posedge clk);
    bus_wr(R_N, 9);
    bus_wr(R_K, 2);
    bus_wr(R_OPSTART, 1);
    bus_rd(R_N, d); check("lock.n", d, 6);
    bus_rd(R_K, d); check("lock.k", d, 0);
    wait_done(cyc);
    bus_rd(R_STATUS, d); check("lock.status", d, 1);
    get_result(r);       check("lock.res", r, 720);

    for (int i = 0; i < 8; i++) begin
      run($sformatf("rnd%0d", i), int'($urandom_range(0, 40)), int'($urandom_range(0, 12)), ov);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
